// File: rtl/time_set_ctrl_if.sv
// Bus between the time-set controller and the clock counters / buttons.
interface time_set_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec_in;
  logic [5:0] min_in;
  logic [5:0] hr_in;
  logic       sec_cnt_en;
  logic       min_cnt_en;
  logic       hr_cnt_en;
  logic       sec_ld;
  logic       min_ld;
  logic       hr_ld;
  logic [5:0] ld_data;
  logic [1:0] sel;
  logic       blink;

  modport master (
    output tick, btn_mode, btn_inc, sec_in, min_in, hr_in,
    input  sec_cnt_en, min_cnt_en, hr_cnt_en, sec_ld, min_ld, hr_ld,
           ld_data, sel, blink
  );

  modport slave (
    input  tick, btn_mode, btn_inc, sec_in, min_in, hr_in,
    output sec_cnt_en, min_cnt_en, hr_cnt_en, sec_ld, min_ld, hr_ld,
           ld_data, sel, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time-setting controller: RUN / set-hour / set-minute / set-second.
module time_set_ctrl #(
  parameter int unsigned HOUR_MAX   = 23,
  parameter int unsigned IDLE_TICKS = 30
) (
  input  logic           clk,
  input  logic           clear,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic              mode_hist_q, mode_hist_d;
  logic              inc_hist_q, inc_hist_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              blink_q, blink_d;
  logic              sec_ld_q, sec_ld_d;
  logic              min_ld_q, min_ld_d;
  logic              hr_ld_q, hr_ld_d;
  logic [5:0]        ld_data_q, ld_data_d;

  logic              mode_edge;
  logic              inc_edge;
  logic              idle_done;
  logic              run_active;
  logic [5:0]        field_val;
  logic [5:0]        field_lim;

  always_comb begin
    mode_edge = bus.btn_mode & ~mode_hist_q;
    inc_edge  = bus.btn_inc & ~inc_hist_q;
    idle_done = (state_q != RUN) && (idle_q == IDLE_W'(IDLE_TICKS));

    field_val = bus.sec_in;
    field_lim = 6'd59;
    case (state_q)
      SET_HR: begin
        field_val = bus.hr_in;
        field_lim = 6'(HOUR_MAX);
      end
      SET_MIN: begin
        field_val = bus.min_in;
        field_lim = 6'd59;
      end
      default: begin
        field_val = bus.sec_in;
        field_lim = 6'd59;
      end
    endcase

    // history registers always track the levels, including during clear
    mode_hist_d = bus.btn_mode;
    inc_hist_d  = bus.btn_inc;
    state_d     = state_q;
    idle_d      = idle_q;
    blink_d     = blink_q;
    sec_ld_d    = 1'b0;
    min_ld_d    = 1'b0;
    hr_ld_d     = 1'b0;
    ld_data_d   = ld_data_q;

    // priority: clear > idle timeout > mode edge > inc edge / tick
    if (clear) begin
      state_d   = RUN;
      idle_d    = '0;
      blink_d   = 1'b0;
      ld_data_d = '0;
    end else if (idle_done) begin
      state_d = RUN;
      idle_d  = '0;
      blink_d = 1'b0;
    end else if (mode_edge) begin
      state_d = state_e'(state_q + 2'd1);
      idle_d  = '0;
      blink_d = (state_q != SET_SEC);
    end else if (state_q != RUN) begin
      if (inc_edge) begin
        idle_d    = '0;
        ld_data_d = (field_val >= field_lim) ? '0 : field_val + 6'd1;
        hr_ld_d   = (state_q == SET_HR);
        min_ld_d  = (state_q == SET_MIN);
        sec_ld_d  = (state_q == SET_SEC);
      end else if (bus.tick) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if (bus.tick) begin
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    mode_hist_q <= mode_hist_d;
    inc_hist_q  <= inc_hist_d;
    idle_q      <= idle_d;
    blink_q     <= blink_d;
    sec_ld_q    <= sec_ld_d;
    min_ld_q    <= min_ld_d;
    hr_ld_q     <= hr_ld_d;
    ld_data_q   <= ld_data_d;
  end

  // clear masks the registered outputs so they read as reset from its first cycle
  assign run_active     = (state_q == RUN) && !clear;
  assign bus.sec_cnt_en = run_active & bus.tick;
  assign bus.min_cnt_en = run_active & bus.tick & (bus.sec_in == 6'd59);
  assign bus.hr_cnt_en  = run_active & bus.tick & (bus.sec_in == 6'd59) & (bus.min_in == 6'd59);
  assign bus.sec_ld     = sec_ld_q & ~clear;
  assign bus.min_ld     = min_ld_q & ~clear;
  assign bus.hr_ld      = hr_ld_q & ~clear;
  assign bus.ld_data    = clear ? '0 : ld_data_q;
  assign bus.sel        = clear ? RUN : state_q;
  assign bus.blink      = blink_q & ~clear;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random stimulus.
module tb_time_set_ctrl;

  localparam int HOUR_MAX   = 23;
  localparam int IDLE_TICKS = 30;

  logic clk;
  logic clear;

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .HOUR_MAX  (HOUR_MAX),
    .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0=RUN 1=hour 2=minute 3=second; ld_field 0=none
  int m_mode;
  int m_prev_mode;
  int m_prev_inc;
  int m_idle;
  int m_blink;
  int m_ld_field;
  int m_ld_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int run_en;
    int s59;
    int m59;
    run_en = (!clear && m_mode == 0) ? 1 : 0;
    s59    = (bus.sec_in == 6'd59) ? 1 : 0;
    m59    = (bus.min_in == 6'd59) ? 1 : 0;
    check_eq("sel",     32'(bus.sel),        clear ? 0 : m_mode);
    check_eq("blink",   32'(bus.blink),      clear ? 0 : m_blink);
    check_eq("sec_en",  32'(bus.sec_cnt_en), run_en & bus.tick);
    check_eq("min_en",  32'(bus.min_cnt_en), run_en & bus.tick & s59);
    check_eq("hr_en",   32'(bus.hr_cnt_en),  run_en & bus.tick & s59 & m59);
    check_eq("hr_ld",   32'(bus.hr_ld),      (!clear && m_ld_field == 1) ? 1 : 0);
    check_eq("min_ld",  32'(bus.min_ld),     (!clear && m_ld_field == 2) ? 1 : 0);
    check_eq("sec_ld",  32'(bus.sec_ld),     (!clear && m_ld_field == 3) ? 1 : 0);
    check_eq("ld_data", 32'(bus.ld_data),    clear ? 0 : m_ld_data);
  endtask

  task automatic advance_model();
    int mode_edge;
    int inc_edge;
    int fields[4];
    int limits[4];
    mode_edge = (bus.btn_mode && !m_prev_mode) ? 1 : 0;
    inc_edge  = (bus.btn_inc && !m_prev_inc) ? 1 : 0;
    fields[1] = bus.hr_in;  limits[1] = HOUR_MAX;
    fields[2] = bus.min_in; limits[2] = 59;
    fields[3] = bus.sec_in; limits[3] = 59;
    fields[0] = 0;          limits[0] = 0;
    m_ld_field = 0;
    if (clear) begin
      m_mode    = 0;
      m_idle    = 0;
      m_blink   = 0;
      m_ld_data = 0;
    end else if (m_mode != 0 && m_idle >= IDLE_TICKS) begin
      m_mode  = 0;
      m_idle  = 0;
      m_blink = 0;
    end else if (mode_edge) begin
      m_mode  = (m_mode + 1) % 4;
      m_idle  = 0;
      m_blink = (m_mode != 0) ? 1 : 0;
    end else if (m_mode != 0) begin
      if (inc_edge) begin
        m_ld_field = m_mode;
        m_ld_data  = (fields[m_mode] >= limits[m_mode]) ? 0 : fields[m_mode] + 1;
        m_idle     = 0;
      end else if (bus.tick) begin
        m_idle++;
      end
      if (bus.tick) m_blink = 1 - m_blink;
    end
    m_prev_mode = bus.btn_mode;
    m_prev_inc  = bus.btn_inc;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic finish_cycle();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    finish_cycle();
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    cycle();
    bus.btn_mode = 1'b0;
    cycle();
  endtask

  task automatic tick_pair();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cycle();
  endtask

  function automatic logic [5:0] rand_field(input int edge_val);
    int r;
    r = int'($urandom_range(0, 5));
    case (r)
      0: rand_field = 6'(edge_val);
      1: rand_field = 6'(edge_val - 1);
      2: rand_field = 6'd63;
      default: rand_field = 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic random_phase(input int n, input int clr_div, input int tick_div, input int btn_div);
    for (int i = 0; i < n; i++) begin
      clear        = ($urandom_range(0, clr_div - 1) == 0);
      bus.tick     = ($urandom_range(0, tick_div - 1) == 0);
      if ($urandom_range(0, btn_div - 1) == 0) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(0, btn_div / 2) == 0) bus.btn_inc = ~bus.btn_inc;
      bus.sec_in   = rand_field(59);
      bus.min_in   = rand_field(59);
      bus.hr_in    = rand_field(HOUR_MAX);
      cycle();
    end
  endtask

  initial begin
    m_mode = 0; m_prev_mode = 0; m_prev_inc = 0; m_idle = 0;
    m_blink = 0; m_ld_field = 0; m_ld_data = 0;
    clear        = 1'b1;
    bus.tick     = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.sec_in   = 6'd0;
    bus.min_in   = 6'd0;
    bus.hr_in    = 6'd0;
    @(posedge clk);
    #1;

    // reset state
    repeat (3) cycle();
    sample();
    check_eq("rst_sel", 32'(bus.sel), 0);
    check_eq("rst_ld_data", 32'(bus.ld_data), 0);
    check_eq("rst_blink", 32'(bus.blink), 0);
    finish_cycle();
    clear = 1'b0;
    cycle();

    // full carry on one tick
    bus.sec_in = 6'd59;
    bus.min_in = 6'd59;
    bus.hr_in  = 6'd3;
    bus.tick   = 1'b1;
    sample();
    check_eq("carry_sec_en", 32'(bus.sec_cnt_en), 1);
    check_eq("carry_min_en", 32'(bus.min_cnt_en), 1);
    check_eq("carry_hr_en",  32'(bus.hr_cnt_en), 1);
    finish_cycle();
    bus.tick = 1'b0;
    sample();
    check_eq("carry_hr_en_after", 32'(bus.hr_cnt_en), 0);
    finish_cycle();

    // three mode edges then second-field wrap
    press_mode();
    press_mode();
    press_mode();
    sample();
    check_eq("sel_sec", 32'(bus.sel), 3);
    finish_cycle();
    bus.btn_inc = 1'b1;
    cycle();
    bus.btn_inc = 1'b0;
    sample();
    check_eq("sec_wrap_ld", 32'(bus.sec_ld), 1);
    check_eq("sec_wrap_data", 32'(bus.ld_data), 0);
    check_eq("sec_wrap_min_ld", 32'(bus.min_ld), 0);
    check_eq("sec_wrap_hr_ld", 32'(bus.hr_ld), 0);
    finish_cycle();
    sample();
    check_eq("sec_ld_one_cycle", 32'(bus.sec_ld), 0);
    finish_cycle();
    press_mode();

    // hour field: wrap, plain increment, ticks gated and blinking
    press_mode();
    bus.hr_in   = 6'd23;
    bus.btn_inc = 1'b1;
    cycle();
    bus.btn_inc = 1'b0;
    sample();
    check_eq("hr_wrap_ld", 32'(bus.hr_ld), 1);
    check_eq("hr_wrap_data", 32'(bus.ld_data), 0);
    finish_cycle();
    bus.hr_in   = 6'd5;
    bus.btn_inc = 1'b1;
    cycle();
    bus.btn_inc = 1'b0;
    sample();
    check_eq("hr_inc_data", 32'(bus.ld_data), 6);
    finish_cycle();
    bus.tick = 1'b1;
    sample();
    check_eq("set_sec_en", 32'(bus.sec_cnt_en), 0);
    check_eq("set_hr_en", 32'(bus.hr_cnt_en), 0);
    check_eq("blink_before_tick", 32'(bus.blink), 1);
    finish_cycle();
    bus.tick = 1'b0;
    sample();
    check_eq("blink_tick1", 32'(bus.blink), 0);
    finish_cycle();
    tick_pair();
    sample();
    check_eq("blink_tick2", 32'(bus.blink), 1);
    finish_cycle();

    // minute: mode and inc rising together
    press_mode();
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    cycle();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    sample();
    check_eq("tie_sel", 32'(bus.sel), 3);
    check_eq("tie_min_ld", 32'(bus.min_ld), 0);
    finish_cycle();

    // idle timeout in second field
    for (int i = 0; i < IDLE_TICKS; i++) tick_pair();
    sample();
    check_eq("timeout_sel", 32'(bus.sel), 0);
    finish_cycle();

    // inc edge on tick 29 restarts the idle count
    press_mode();
    press_mode();
    press_mode();
    for (int i = 0; i < IDLE_TICKS - 2; i++) tick_pair();
    bus.tick    = 1'b1;
    bus.btn_inc = 1'b1;
    cycle();
    bus.tick    = 1'b0;
    bus.btn_inc = 1'b0;
    cycle();
    for (int i = 0; i < IDLE_TICKS - 1; i++) tick_pair();
    sample();
    check_eq("restart_still_set", 32'(bus.sel), 3);
    finish_cycle();
    tick_pair();
    sample();
    check_eq("restart_timeout_sel", 32'(bus.sel), 0);
    finish_cycle();

    // inc held through a clear pulse while setting hours
    press_mode();
    clear       = 1'b1;
    bus.btn_inc = 1'b1;
    cycle();
    cycle();
    clear = 1'b0;
    repeat (3) cycle();
    sample();
    check_eq("held_clr_sel", 32'(bus.sel), 0);
    check_eq("held_clr_hr_ld", 32'(bus.hr_ld), 0);
    finish_cycle();
    repeat (4) cycle();
    bus.btn_inc = 1'b0;
    cycle();

    // pending load cancelled by clear
    press_mode();
    bus.btn_inc = 1'b1;
    cycle();
    bus.btn_inc = 1'b0;
    clear       = 1'b1;
    sample();
    check_eq("cancel_hr_ld", 32'(bus.hr_ld), 0);
    check_eq("cancel_sel", 32'(bus.sel), 0);
    finish_cycle();
    clear = 1'b0;
    cycle();

    // random stimulus: busy buttons, then sparse buttons to reach timeouts
    random_phase(3000, 200, 3, 12);
    clear = 1'b0;
    random_phase(3000, 1000, 2, 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
